ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative, parametrised multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU. It replaces single-cycle combinational MULT/MULTU/DIV/DIVU with a WIDTH-cycle shift-add multiplier and restoring divider. It adds a start/busy/done handshake, divide-by-zero flagging, pipeline flush, and MTHI/MTLO writes. The EX stage stalls on Busy and reads Hi/Lo for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; legal values are ≥4.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- A  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- B  in  WIDTH  rt operand (multiplier/divisor).
- Flush  in  1  abort the in-flight operation.
- Busy  out  1  an operation is in progress.
- Done  out  1  one-cycle pulse; Hi/Lo hold a new result.
- DivZero  out  1  last completed divide had B=0; held until the next completion.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state IDLE.
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE:
  - Start with Op 0–3 latches A, B and Op, then goes to PREP.
  - Start with Op 4/5 writes Hi (or Lo) ← A at the same edge. The unit stays IDLE; Busy and Done are not asserted.
  - Op 6–7 are ignored.
- PREP:
  - Signed ops convert operands to magnitudes and record the signs: sq = sA^sB for the quotient/product, sr = sA for the remainder.
  - Clears the accumulator and loads the counter with WIDTH.
  - Goes to ITER.
- ITER: performs one step per cycle. After WIDTH steps it goes to FIX.
  - Multiply step: conditional add of the multiplicand to the upper half of the 2·WIDTH accumulator, then a right shift.
  - Divide step: shift the remainder left, trial subtract, set the quotient bit.
- FIX: applies sign correction, writes Hi/Lo, pulses Done and returns to IDLE.
  - Product: negate the 2W result if sq=1. Hi gets the upper half, Lo the lower half.
  - Quotient goes to Lo; negate if sq=1.
  - Remainder goes to Hi; negate if sr=1 (remainder takes the dividend's sign).
- Divide by zero (DIV/DIVU, B=0): full latency still applies. Result is Lo=all ones, Hi=A as originally presented, DivZero=1.
- Signed overflow (−2^(W−1) / −1): Lo=0x80…0, Hi=0, DivZero=0. No trap.
- DivZero updates only on a divide completion. Any multiply completion clears it.
- Flush:
  - In PREP, ITER or FIX, Flush returns the unit to IDLE at the next edge. Hi, Lo and DivZero are unchanged and Done is not asserted. Flush takes priority over the FIX write.
  - In IDLE, Flush suppresses a simultaneous Start, including MTHI/MTLO.
- Start while Busy=1 is ignored and has no side effects.
- Reset asserted mid-operation forces all reset values immediately, with no Done.

## Timing
- Start is sampled at edge E0. Busy=1 from E0 through E(WIDTH+2).
- Hi/Lo/DivZero are updated and Done=1 for exactly the cycle following E(WIDTH+2). Busy=0 in that same cycle. Latency is WIDTH+2 cycles (34 at WIDTH=32).
- A new Start can be accepted in the Done cycle (back-to-back issue).
- MTHI/MTLO: the register is visible the cycle after E0.
- A and B may change after E0; they are latched.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mdu_pkg` holds:
  - Op encoding localparams (MDU_MULT … MDU_MTLO).
  - FSM state encoding.
  - Function clog2 for the counter width, $clog2(WIDTH)+1.
- One combinational sub-module, `mdu_abs`, is instantiated twice (A and B). It takes a WIDTH-bit value and a signed flag and returns the magnitude and the sign bit. The FIX negation reuses its two's-complement logic.
- The datapath holds a 2·WIDTH accumulator shared by multiply (product) and divide (remainder:quotient) to minimise registers.

## Test plan
All scenarios use WIDTH=32.
1. MULT A=5, B=3: Busy for 34 cycles → Done pulse, Hi=00000000, Lo=0000000F. Also MULT A=FFFFFFFE (−2), B=3 → Hi=FFFFFFFF, Lo=FFFFFFFA.
2. MULTU A=FFFFFFFF, B=FFFFFFFF → Hi=FFFFFFFE, Lo=00000001. Issue DIVU 0000000F/3 in the Done cycle → Lo=5, Hi=0, 34 cycles later.
3. DIV A=FFFFFFF9 (−7), B=2 → Lo=FFFFFFFD, Hi=FFFFFFFF. DIV 80000000/FFFFFFFF → Lo=80000000, Hi=0, DivZero=0.
4. DIVU A=12345678, B=0 → after 34 cycles Done, DivZero=1, Lo=FFFFFFFF, Hi=12345678. A following MULT clears DivZero.
5. Start MULT, assert Flush at cycle 10 → Busy=0 next cycle, no Done, Hi/Lo keep their prior values. A second Start (DIV) issued while Busy is ignored, and the first result is unaffected.
6. MTHI A=DEADBEEF → Hi=DEADBEEF next cycle, Busy and Done stay 0. Start+Flush with MTLO → Lo unchanged. RST pulse mid-DIV → all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and helpers shared by the multiply/divide unit
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX
    } mdu_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_abs.sv
// rtl/mdu_abs.sv - magnitude/sign extraction, also usable as a conditional two's-complement negator
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             is_signed,
    input  logic             neg_en,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    assign sign = is_signed & val[WIDTH-1];
    assign mag  = (sign | neg_en) ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative shift-add multiplier and restoring divider with HI/LO registers
module ex_muldiv
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sq_q, sq_d, sr_q, sr_d, bz_q, bz_d;
    logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d;

    logic             is_mul, is_signed, in_prep, in_fix, lo_zero;
    logic [WIDTH-1:0] acc_hi, acc_lo, abs_a_val, abs_b_val, mag_a, mag_b;
    logic             sgn_a, sgn_b, neg_a, neg_b;
    logic [WIDTH:0]   mul_sum, div_pr, div_diff;

    assign acc_hi    = acc_q[W2-1:WIDTH];
    assign acc_lo    = acc_q[WIDTH-1:0];
    assign is_mul    = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
    assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign in_prep   = (state_q == ST_PREP);
    assign in_fix    = (state_q == ST_FIX);
    assign lo_zero   = (acc_lo == '0);

    // In FIX the abs units become conditional negators on the accumulator halves;
    // the product high half only takes the +1 carry when the low half is zero.
    assign abs_a_val = in_fix ? acc_lo : a_q;
    assign abs_b_val = in_fix ? acc_hi : b_q;
    assign neg_a     = in_fix & sq_q;
    assign neg_b     = in_fix & (is_mul ? (sq_q & lo_zero) : sr_q);

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val       (abs_a_val),
        .is_signed (in_prep & is_signed),
        .neg_en    (neg_a),
        .mag       (mag_a),
        .sign      (sgn_a)
    );

    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val       (abs_b_val),
        .is_signed (in_prep & is_signed),
        .neg_en    (neg_b),
        .mag       (mag_b),
        .sign      (sgn_b)
    );

    assign mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign div_pr   = acc_q[W2-1:WIDTH-1];
    assign div_diff = div_pr - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        bz_d    = bz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    if (Op <= MDU_DIVU) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = Op;
                        state_d = ST_PREP;
                    end else if (Op == MDU_MTHI) begin
                        hi_d = A;
                    end else if (Op == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_PREP: begin
                a_d     = mag_a;
                b_d     = mag_b;
                sq_d    = sgn_a ^ sgn_b;
                sr_d    = sgn_a;
                bz_d    = (b_q == '0);
                acc_d   = {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                cnt_d   = CNT_W'(WIDTH);
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (is_mul) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (div_diff[WIDTH]) begin
                    acc_d = {div_pr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_mul) begin
                    hi_d = (sq_q && !lo_zero) ? ~acc_hi : mag_b;
                    lo_d = mag_a;
                    dz_d = 1'b0;
                end else begin
                    hi_d = mag_b;
                    lo_d = bz_q ? '1 : mag_a;
                    dz_d = bz_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over the FIX write-back.
        if (Flush && state_q != ST_IDLE) begin
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = dz_q;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
        int               cyc;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    ex_muldiv #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Flush   (Flush),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        p     = '0;
        e.dz  = 1'b0;
        e.cyc = 0;
        if (op == MDU_MULT)  p = 64'(sa * sb);
        if (op == MDU_MULTU) p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
        if (op == MDU_DIV || op == MDU_DIVU) begin
            if (b == '0) begin
                e.hi = a;
                e.lo = '1;
                e.dz = 1'b1;
            end else if (op == MDU_DIV) begin
                e.lo = 32'(sa / sb);
                e.hi = 32'(sa % sb);
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end
        return e;
    endfunction

    // Called at a falling edge; Start is sampled at the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit track);
        exp_t e;
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        if (track) begin
            e     = model(op, a, b);
            e.cyc = cyc + WIDTH + 3;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((Busy || sb_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq("idle_timeout", 64'(n < 200), 64'd1);
    endtask

    always @(negedge CLK) begin
        if (!RST && Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 64'(Done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("hi", 64'(Hi), 64'(mon_e.hi));
                check_eq("lo", 64'(Lo), 64'(mon_e.lo));
                check_eq("divzero", 64'(DivZero), 64'(mon_e.dz));
                check_eq("latency", 64'(cyc), 64'(mon_e.cyc));
                check_eq("busy_at_done", 64'(Busy), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] hi0;
        logic [WIDTH-1:0] lo0;
        int               n;
        RST   = 1'b1;
        Start = 1'b0;
        Flush = 1'b0;
        Op    = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_hi", 64'(Hi), 64'd0);
        check_eq("rst_lo", 64'(Lo), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_dz", 64'(DivZero), 64'd0);

        issue(MDU_MULT, 32'd5, 32'd3, 1'b1);
        check_eq("busy_after_start", 64'(Busy), 64'd1);
        wait_idle();
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle();

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_eq("b2b_done_seen", 64'(n < 100), 64'd1);
        issue(MDU_DIVU, 32'h0000_000F, 32'd3, 1'b1);
        wait_idle();

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        issue(MDU_DIVU, 32'h1234_5678, 32'd0, 1'b1);
        wait_idle();
        issue(MDU_DIV, 32'hF000_0000, 32'd0, 1'b1);
        wait_idle();
        issue(MDU_MULT, 32'd7, 32'd6, 1'b1);
        wait_idle();

        hi0 = Hi;
        lo0 = Lo;
        issue(MDU_MULT, 32'd77, 32'd99, 1'b0);
        repeat (8) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        check_eq("flush_busy", 64'(Busy), 64'd0);
        check_eq("flush_hi", 64'(Hi), 64'(hi0));
        check_eq("flush_lo", 64'(Lo), 64'(lo0));
        repeat (40) @(negedge CLK);

        issue(MDU_MULT, 32'h0000_1234, 32'h0000_0010, 1'b1);
        repeat (3) @(negedge CLK);
        issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
        wait_idle();
        repeat (40) @(negedge CLK);

        issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check_eq("mthi_hi", 64'(Hi), 64'hDEAD_BEEF);
        check_eq("mthi_busy", 64'(Busy), 64'd0);
        check_eq("mthi_done", 64'(Done), 64'd0);
        lo0   = Lo;
        Flush = 1'b1;
        issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
        Flush = 1'b0;
        check_eq("mtlo_flushed", 64'(Lo), 64'(lo0));
        issue(MDU_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0);
        check_eq("mtlo_lo", 64'(Lo), 64'h0BAD_F00D);
        issue(3'd7, 32'h1111_1111, 32'd2, 1'b0);
        check_eq("nop_busy", 64'(Busy), 64'd0);
        check_eq("nop_hi", 64'(Hi), 64'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]       rop;
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 9));
            issue(rop, ra, rb, 1'b1);
            wait_idle();
        end

        issue(MDU_DIVU, 32'h1234_5678, 32'd0, 1'b1);
        wait_idle();
        issue(MDU_DIV, 32'd100, 32'd3, 1'b0);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_eq("arst_hi", 64'(Hi), 64'd0);
        check_eq("arst_lo", 64'(Lo), 64'd0);
        check_eq("arst_busy", 64'(Busy), 64'd0);
        check_eq("arst_done", 64'(Done), 64'd0);
        check_eq("arst_dz", 64'(DivZero), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
